// File: rtl/risc_decode_pkg.sv
// Shared types for the RISC-V decode stage.
//   instr_id_e : decoded instruction identifier
//   alu_ctrl_e : ALU operation requested from execute
//   OPC_*      : major opcode constants (instr[6:0])
//   decoded_t  : one decoded instruction, used as the FIFO entry type
// XLEN sets the stored immediate/PC width. Instruction encodings are 32 bits,
// so every immediate is produced at 32 bits and sign-extended at the outputs.
package risc_decode_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ID_NULL  = 5'd0,
    ID_ADD   = 5'd1,
    ID_SUB   = 5'd2,
    ID_XOR   = 5'd3,
    ID_OR    = 5'd4,
    ID_AND   = 5'd5,
    ID_SLL   = 5'd6,
    ID_SRL   = 5'd7,
    ID_SRA   = 5'd8,
    ID_SLT   = 5'd9,
    ID_ADDI  = 5'd10,
    ID_XORI  = 5'd11,
    ID_ORI   = 5'd12,
    ID_ANDI  = 5'd13,
    ID_SLLI  = 5'd14,
    ID_SRLI  = 5'd15,
    ID_SRAI  = 5'd16,
    ID_LW    = 5'd17,
    ID_SW    = 5'd18,
    ID_JAL   = 5'd19,
    ID_BEQ   = 5'd20,
    ID_BNE   = 5'd21,
    ID_LUI   = 5'd22,
    ID_AUIPC = 5'd23,
    ID_JALR  = 5'd24,
    ID_MUL   = 5'd25,
    ID_DIV   = 5'd26,
    ID_REM   = 5'd27
  } instr_id_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_XOR = 4'd2,
    ALU_OR  = 4'd3,
    ALU_AND = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8,
    ALU_MUL = 4'd9,
    ALU_DIV = 4'd10,
    ALU_REM = 4'd11
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    instr_id_e       id;
    alu_ctrl_e       alu;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } decoded_t;

endpackage

// File: rtl/instr_decode_logic.sv
// Pure combinational RV32I decoder (subset plus branches, LUI/AUIPC, JALR).
// Ports:
//   instr (in, WORD_SIZE) raw instruction
//   pc    (in, WORD_SIZE) instruction address, carried through
//   dec   (out, decoded_t) id, ALU op, register indices, immediate, illegal
// Optional feature: define DECODE_MEXT_EN to decode MUL/DIV/REM
// (opcode OP, funct7 0000001); otherwise those encodings are illegal.
module instr_decode_logic
  import risc_decode_pkg::*;
#(
  parameter int WORD_SIZE = XLEN
) (
  input  logic [WORD_SIZE-1:0] instr,
  input  logic [WORD_SIZE-1:0] pc,
  output decoded_t             dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  instr_id_e   id;
  alu_ctrl_e   alu;
  logic [31:0] imm;
  logic        legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Anything not explicitly recognised keeps the defaults: NULL / ADD / imm 0
  // and is flagged illegal. R-type entries leave imm at 0.
  always_comb begin
    id    = ID_NULL;
    alu   = ALU_ADD;
    imm   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          case (f3)
            3'b000:  begin id = ID_ADD; alu = ALU_ADD; end
            3'b001:  begin id = ID_SLL; alu = ALU_SLL; end
            3'b010:  begin id = ID_SLT; alu = ALU_SLT; end
            3'b100:  begin id = ID_XOR; alu = ALU_XOR; end
            3'b101:  begin id = ID_SRL; alu = ALU_SRL; end
            3'b110:  begin id = ID_OR;  alu = ALU_OR;  end
            3'b111:  begin id = ID_AND; alu = ALU_AND; end
            default: legal = 1'b0;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000) begin id = ID_SUB; alu = ALU_SUB; legal = 1'b1; end
          if (f3 == 3'b101) begin id = ID_SRA; alu = ALU_SRA; legal = 1'b1; end
        end
`ifdef DECODE_MEXT_EN
        else if (f7 == 7'b0000001) begin
          if (f3 == 3'b000) begin id = ID_MUL; alu = ALU_MUL; legal = 1'b1; end
          if (f3 == 3'b100) begin id = ID_DIV; alu = ALU_DIV; legal = 1'b1; end
          if (f3 == 3'b110) begin id = ID_REM; alu = ALU_REM; legal = 1'b1; end
        end
`endif
      end
      OPC_OP_IMM: begin
        imm   = imm_i;
        legal = 1'b1;
        case (f3)
          3'b000: begin id = ID_ADDI; alu = ALU_ADD; end
          3'b100: begin id = ID_XORI; alu = ALU_XOR; end
          3'b110: begin id = ID_ORI;  alu = ALU_OR;  end
          3'b111: begin id = ID_ANDI; alu = ALU_AND; end
          3'b001: begin
            if (f7 == 7'b0000000) begin id = ID_SLLI; alu = ALU_SLL; end
            else legal = 1'b0;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      begin id = ID_SRLI; alu = ALU_SRL; end
            else if (f7 == 7'b0100000) begin id = ID_SRAI; alu = ALU_SRA; end
            else legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
        if (!legal) imm = '0;
      end
      OPC_LOAD:   if (f3 == 3'b010) begin id = ID_LW;   imm = imm_i; legal = 1'b1; end
      OPC_STORE:  if (f3 == 3'b010) begin id = ID_SW;   imm = imm_s; legal = 1'b1; end
      OPC_JALR:   if (f3 == 3'b000) begin id = ID_JALR; imm = imm_i; legal = 1'b1; end
      OPC_JAL:    begin id = ID_JAL;   imm = imm_j; legal = 1'b1; end
      OPC_LUI:    begin id = ID_LUI;   imm = imm_u; legal = 1'b1; end
      OPC_AUIPC:  begin id = ID_AUIPC; imm = imm_u; legal = 1'b1; end
      OPC_BRANCH: begin
        if (f3 == 3'b000) begin id = ID_BEQ; alu = ALU_SUB; imm = imm_b; legal = 1'b1; end
        if (f3 == 3'b001) begin id = ID_BNE; alu = ALU_SUB; imm = imm_b; legal = 1'b1; end
      end
      default: ;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.id      = id;
    dec.alu     = alu;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.imm     = imm;
    dec.pc      = pc[XLEN-1:0];
    dec.illegal = !legal;
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered, back-pressured decode stage between fetch and execute.
// Decoded instructions queue in a DEPTH-entry FIFO; the head entry is held in
// an output register so data fields stay stable while stalled or empty.
// Ports:
//   clk, rst_n (async, active low), flush (empties FIFO at next edge)
//   in_valid/in_ready/in_instr/in_pc       : fetch side, in_ready = !full
//   out_valid/out_ready                    : execute side, out_valid = !empty
//   out_instr_id/out_alu_ctrl/out_rd/out_rs1/out_rs2/out_imm/out_pc/out_illegal
//   illegal_cnt : saturating count of accepted illegal instructions
// Optional feature: DECODE_MEXT_EN enables MUL/DIV/REM in instr_decode_logic.
module instruction_decode_stage
  import risc_decode_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_instr,
  input  logic [WORD_SIZE-1:0] in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_instr_id,
  output logic [3:0]           out_alu_ctrl,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [WORD_SIZE-1:0] out_imm,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic                 out_illegal,
  output logic [CNT_W-1:0]     illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  decoded_t             dec;
  decoded_t             mem [DEPTH];
  decoded_t             head_q;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]        count;
  logic                 push, pop;

  instr_decode_logic #(.WORD_SIZE(WORD_SIZE)) u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec)
  );

  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign rd_next   = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // head_q mirrors the FIFO head. It loads the incoming entry when the FIFO
  // is (or is about to become) empty, otherwise the entry behind the head on
  // a pop; when the FIFO drains or flushes it simply holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && (count == '0 || (count == CNT_ONE && pop)))
        head_q <= dec;
      else if (pop && count > CNT_ONE)
        head_q <= mem[rd_next];
    end
  end

  // Counts accepted illegal instructions, including one accepted in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (in_valid && in_ready && dec.illegal && illegal_cnt != '1)
      illegal_cnt <= illegal_cnt + 1'b1;
  end

  assign out_instr_id = head_q.id;
  assign out_alu_ctrl = head_q.alu;
  assign out_rd       = head_q.rd;
  assign out_rs1      = head_q.rs1;
  assign out_rs2      = head_q.rs2;
  assign out_imm      = WORD_SIZE'($signed(head_q.imm));
  assign out_pc       = WORD_SIZE'(head_q.pc);
  assign out_illegal  = head_q.illegal;

endmodule
